// File: rtl/traffic_pkg.sv
// traffic_pkg: green-timer FSM states and ms-to-cycles conversion shared by the traffic blocks
package traffic_pkg;
    typedef enum logic [2:0] {IDLE, LATCH, CALC, CLAMP, HOLD} state_t;
    function automatic longint unsigned ms_to_cyc(input longint unsigned ms, input longint unsigned freq);
        return ms * freq / 64'd1000;
    endfunction
endpackage

// File: rtl/veh_counter.sv
// veh_counter: sensor -> 2-flop sync -> rising-edge pulse -> saturating count, clr restarts at 0 (or 1 if a pulse lands with it)
module veh_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    logic [2:0] sh;
    logic       pulse;
    assign pulse = sh[1] & ~sh[2];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
        end else begin
            sh  <= {sh[1:0], sensor};
            cnt <= clr ? CNT_W'(pulse) : (pulse && !(&cnt)) ? cnt + 1'b1 : cnt;
        end
    end
endmodule

// File: rtl/adaptive_green_timer.sv
// adaptive_green_timer: per-approach vehicle counts turned into a clamped green time on req; busy/dly_valid/dly_ack handshake
module adaptive_green_timer
    import traffic_pkg::*;
#(
    parameter int NUM_APPR = 4,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BASE_MS  = 200,
    parameter int STEP_MS  = 25,
    parameter int MAX_MS   = 600,
    parameter int CNT_W    = 6,
    localparam int SEL_W   = (NUM_APPR > 1) ? $clog2(NUM_APPR) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_APPR-1:0]       sensor,
    input  logic                      req,
    input  logic [SEL_W-1:0]          req_sel,
    output logic                      busy,
    output logic                      dly_valid,
    input  logic                      dly_ack,
    output logic [31:0]               dly_cycles,
    output logic [NUM_APPR*CNT_W-1:0] veh_cnt
);
    localparam longint unsigned BASE_CYC = ms_to_cyc(64'(BASE_MS), 64'(CLK_FREQ));
    localparam longint unsigned STEP_CYC = ms_to_cyc(64'(STEP_MS), 64'(CLK_FREQ));
    localparam longint unsigned MAX_CYC  = ms_to_cyc(64'(MAX_MS), 64'(CLK_FREQ));
    state_t           state, nxt;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] snap, snap_q;
    logic [39:0]      raw;
    logic [CNT_W-1:0] cnt_a [NUM_APPR];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = state;
        nxt = (state == IDLE)  ? (req ? LATCH : IDLE) :
              (state == LATCH) ? CALC :
              (state == CALC)  ? CLAMP :
              (state == CLAMP) ? HOLD :
              (dly_ack ? IDLE : HOLD);
    end
    always_comb begin
        snap = '0;
        for (int i = 0; i < NUM_APPR; i++)
            if (sel_q == SEL_W'(i)) snap = cnt_a[i];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= '0;
            snap_q     <= '0;
            raw        <= '0;
            dly_cycles <= 32'(BASE_CYC);
        end else begin
            if (state == IDLE && req) sel_q <= req_sel;
            if (state == LATCH) snap_q <= snap;
            if (state == CALC) raw <= 40'(BASE_CYC) + 40'(snap_q) * 40'(STEP_CYC);
            if (state == CLAMP) dly_cycles <= (raw > 40'(MAX_CYC)) ? 32'(MAX_CYC) : raw[31:0];
        end
    end
    assign busy      = state != IDLE;
    assign dly_valid = state == HOLD;
    for (genvar i = 0; i < NUM_APPR; i++) begin : g_cnt
        veh_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .sensor (sensor[i]),
            .clr    (state == LATCH && sel_q == SEL_W'(i)),
            .cnt    (cnt_a[i])
        );
        assign veh_cnt[i*CNT_W +: CNT_W] = cnt_a[i];
    end
endmodule

// File: tb/tb_adaptive_green_timer.sv
// tb_adaptive_green_timer: directed scoreboard bench for adaptive_green_timer at 1 cycle/ms
module tb_adaptive_green_timer;
    logic        clk = 0, rst = 1, req = 0, dly_ack = 0;
    logic [3:0]  sensor = '0;
    logic [1:0]  req_sel = '0;
    logic        busy, dly_valid;
    logic [31:0] dly_cycles;
    logic [23:0] veh_cnt;
    logic        req5 = 0, ack5 = 0;
    logic [2:0]  sel5 = '0;
    logic [4:0]  sensor5 = '0;
    logic        busy5, valid5;
    logic [31:0] cyc5;
    logic [29:0] cnt5;
    int          n_vec = 0, n_miss = 0, lat = 0, seen = 0;
    longint      q[$];

    adaptive_green_timer #(.NUM_APPR(4), .CLK_FREQ(1000), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .sensor(sensor), .req(req), .req_sel(req_sel), .busy(busy),
        .dly_valid(dly_valid), .dly_ack(dly_ack), .dly_cycles(dly_cycles), .veh_cnt(veh_cnt));

    adaptive_green_timer #(.NUM_APPR(5), .CLK_FREQ(1000), .CNT_W(6)) dut5 (
        .clk(clk), .rst(rst), .sensor(sensor5), .req(req5), .req_sel(sel5), .busy(busy5),
        .dly_valid(valid5), .dly_ack(ack5), .dly_cycles(cyc5), .veh_cnt(cnt5));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
        $fatal(1);
    end

    function automatic longint fld(input logic [23:0] v, input int i);
        return longint'(v[i*6 +: 6]);
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int idx, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); sensor[idx] = 1'b1;
            repeat (2) @(negedge clk);
            sensor[idx] = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] sel, input longint exp);
        q.push_back(exp);
        @(negedge clk); req = 1'b1; req_sel = sel;
        @(negedge clk); req = 1'b0; lat = 1;
        chk("busy_rise", longint'(busy), 1);
    endtask

    task automatic wait_valid(input string tag);
        while (!dly_valid && lat < 20) begin
            @(negedge clk); lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_dly"}, longint'(dly_cycles), q.pop_front());
    endtask

    task automatic ack_tx(input string tag);
        chk({tag, "_busy_hold"}, longint'(busy), 1);
        dly_ack = 1'b1;
        @(negedge clk); dly_ack = 1'b0;
        chk({tag, "_busy_clr"}, longint'(busy), 0);
        chk({tag, "_valid_clr"}, longint'(dly_valid), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_valid", longint'(dly_valid), 0);
        chk("rst_dly", longint'(dly_cycles), 200);
        chk("rst_cnt", longint'(veh_cnt), 0);
        rst = 1'b0;
        // idle approach gives the base time
        issue(2'd2, 200);
        wait_valid("t1");
        ack_tx("t1");
        // five arrivals extend by 5*25
        pulse(1, 5);
        chk("t2_cnt1", fld(veh_cnt, 1), 5);
        issue(2'd1, 325);
        @(negedge clk); lat++;
        chk("t2_cnt1_cleared", fld(veh_cnt, 1), 0);
        wait_valid("t2");
        ack_tx("t2");
        // saturation and clamp
        pulse(0, 70);
        chk("t3_sat", fld(veh_cnt, 0), 63);
        issue(2'd0, 600);
        wait_valid("t3");
        chk("t3_raw", longint'(dut.raw), 1775);
        ack_tx("t3");
        // arrival coincident with the LATCH cycle survives the clear
        pulse(3, 2);
        chk("t4_cnt3_pre", fld(veh_cnt, 3), 2);
        @(negedge clk); sensor[3] = 1'b1;
        q.push_back(250);
        @(negedge clk); req = 1'b1; req_sel = 2'd3;
        @(negedge clk); req = 1'b0; lat = 1;
        @(negedge clk); lat++;
        chk("t4_cnt3_post", fld(veh_cnt, 3), 1);
        wait_valid("t4");
        @(negedge clk); req = 1'b1; req_sel = 2'd0;
        @(negedge clk); req = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_hold_valid", longint'(dly_valid), 1);
        chk("t4_hold_dly", longint'(dly_cycles), 250);
        ack_tx("t4");
        repeat (3) @(negedge clk);
        chk("t4_no_queue", longint'(busy), 0);
        sensor[3] = 1'b0;
        // reset in CALC aborts
        pulse(0, 2);
        pulse(2, 3);
        chk("t5_cnt2_pre", fld(veh_cnt, 2), 3);
        @(negedge clk); req = 1'b1; req_sel = 2'd1;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_busy", longint'(busy), 0);
        chk("t5_valid", longint'(dly_valid), 0);
        chk("t5_dly", longint'(dly_cycles), 200);
        chk("t5_cnt", longint'(veh_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (dly_valid) seen = 1;
        end
        chk("t5_no_valid", seen, 0);
        issue(2'd2, 200);
        wait_valid("t5_after");
        ack_tx("t5_after");
        // ack in IDLE is ignored
        dly_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_ack_busy", longint'(busy), 0);
        chk("t6_ack_valid", longint'(dly_valid), 0);
        chk("t6_ack_dly", longint'(dly_cycles), 200);
        dly_ack = 1'b0;
        // out-of-range select on a 5-approach instance
        pulse(0, 1);
        q.push_back(200);
        @(negedge clk); req5 = 1'b1; sel5 = 3'd5;
        @(negedge clk); req5 = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_sel5_early", longint'(valid5), 0);
        @(negedge clk);
        chk("t6_sel5_valid", longint'(valid5), 1);
        chk("t6_sel5_dly", longint'(cyc5), q.pop_front());
        ack5 = 1'b1;
        @(negedge clk); ack5 = 1'b0;
        chk("t6_sel5_busy", longint'(busy5), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
